mbus_ext_int_ctrl: RTL

//  Upstream requester for mbus_wire_ctrl's EXTERNAL_INT input. On a layer interrupt request it

---
 rtl/mbus_ext_int_ctrl_pkg.sv | 18 +
 rtl/mbus_sync2.sv | 21 ++
 rtl/mbus_ext_int_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mbus_ext_int_ctrl_pkg.sv
// Shared state encodings and default timing parameters for the MBus external interrupt requester.
package mbus_ext_int_ctrl_pkg;

    localparam int unsigned IDLE_CYCLES_DEF    = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
    localparam int unsigned BACKOFF_CYCLES_DEF = 64;
    localparam int unsigned MAX_RETRY_DEF      = 3;
    localparam int unsigned CNT_W_DEF          = 10;

    typedef enum logic [2:0] {
        MBUS_INT_IDLE      = 3'd0,
        MBUS_INT_WAIT_IDLE = 3'd1,
        MBUS_INT_ASSERT    = 3'd2,
        MBUS_INT_BACKOFF   = 3'd3,
        MBUS_INT_WAIT_DONE = 3'd4
    } int_state_e;

endpackage

// File: rtl/mbus_sync2.sv
// Two-flop synchroniser for an MBus line; resets to 1 so an idle bus is seen straight out of reset.
module mbus_sync2 (
    input  logic CLK,
    input  logic RESETn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mbus_ext_int_ctrl.sv
// Requests an MBus interrupt via EXTERNAL_INT once the bus is quiet, waits for the master's CLKIN
// fall, then reports ACK after the transaction ends; unanswered attempts time out, back off and retry.
module mbus_ext_int_ctrl
    import mbus_ext_int_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES    = IDLE_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned BACKOFF_CYCLES = BACKOFF_CYCLES_DEF,
    parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic CLKIN,
    input  logic DIN,
    input  logic REQ_INT,
    output logic EXTERNAL_INT,
    output logic INT_ACK,
    output logic INT_FAIL,
    output logic BUSY
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic               clkin_s, din_s, clkin_s_d;
    logic               clk_fall, bus_idle;
    logic [CNT_W-1:0]   idle_cnt;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    int_state_e         state;

    mbus_sync2 u_sync_clkin (.CLK(CLK), .RESETn(RESETn), .d(CLKIN), .q(clkin_s));
    mbus_sync2 u_sync_din   (.CLK(CLK), .RESETn(RESETn), .d(DIN),   .q(din_s));

    assign clk_fall = clkin_s_d & ~clkin_s;
    assign bus_idle = (idle_cnt == CNT_W'(IDLE_CYCLES));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            clkin_s_d <= 1'b1;
            idle_cnt  <= '0;
        end else begin
            clkin_s_d <= clkin_s;
            if (!(clkin_s & din_s))
                idle_cnt <= '0;
            else if (!bus_idle)
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= MBUS_INT_IDLE;
            cyc_cnt      <= '0;
            retry_cnt    <= '0;
            EXTERNAL_INT <= 1'b0;
            INT_ACK      <= 1'b0;
            INT_FAIL     <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            INT_ACK  <= 1'b0;
            INT_FAIL <= 1'b0;
            case (state)
                MBUS_INT_IDLE: begin
                    retry_cnt <= '0;
                    cyc_cnt   <= '0;
                    if (REQ_INT) begin
                        state <= MBUS_INT_WAIT_IDLE;
                        BUSY  <= 1'b1;
                    end
                end
                MBUS_INT_WAIT_IDLE: begin
                    cyc_cnt <= '0;
                    if (!REQ_INT) begin
                        state <= MBUS_INT_IDLE;
                        BUSY  <= 1'b0;
                    end else if (bus_idle) begin
                        state        <= MBUS_INT_ASSERT;
                        EXTERNAL_INT <= 1'b1;
                    end
                end
                MBUS_INT_ASSERT: begin
                    // A master answer beats a timeout landing on the same cycle.
                    if (clk_fall) begin
                        state        <= MBUS_INT_WAIT_DONE;
                        EXTERNAL_INT <= 1'b0;
                        cyc_cnt      <= '0;
                    end else if (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        EXTERNAL_INT <= 1'b0;
                        cyc_cnt      <= '0;
                        if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                            state    <= MBUS_INT_IDLE;
                            INT_FAIL <= 1'b1;
                            BUSY     <= 1'b0;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= MBUS_INT_BACKOFF;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                MBUS_INT_BACKOFF: begin
                    if (cyc_cnt == CNT_W'(BACKOFF_CYCLES - 1)) begin
                        state   <= MBUS_INT_WAIT_IDLE;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                MBUS_INT_WAIT_DONE: begin
                    cyc_cnt <= '0;
                    if (bus_idle) begin
                        state   <= MBUS_INT_IDLE;
                        INT_ACK <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    state        <= MBUS_INT_IDLE;
                    EXTERNAL_INT <= 1'b0;
                    BUSY         <= 1'b0;
                    cyc_cnt      <= '0;
                end
            endcase
        end
    end

endmodule
